// File: rtl/diff_pipe.sv
// -----------------------------------------------------------------------------
// diff_pipe -- pipelined difference unit for the miniRISC datapath.
//
// Computes a-b (signed wrap), |a-b| or a running sum of absolute differences
// through a fixed-latency pipeline of STAGES registered stages. All stages
// advance together when the output register is empty or being consumed, so
// the latency is exactly STAGES cycles whenever the consumer keeps up.
//
// Parameters:
//   WIDTH      operand / result width (>= 4)
//   STAGES     pipeline depth = latency in cycles (1..4)
//   ACC_WIDTH  SAD accumulator width (>= WIDTH), saturating
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready  operand handshake; in_ready depends only on the
//                       output handshake, never on in_valid
//   a, b                minuend, subtrahend
//   mode                00 signed sub, 01 abs diff, 10 SAD accumulate,
//                       11 behaves as 00
//   acc_clr             synchronous accumulator clear (clear-then-add when
//                       it meets a SAD beat entering the output register)
//   out_valid, out_ready result handshake
//   out                 result
//   zero, neg, borrow, ovf  status flags registered with out
//   acc                 SAD accumulator
// -----------------------------------------------------------------------------
module diff_pipe #(
    parameter int WIDTH     = 32,
    parameter int STAGES    = 2,
    parameter int ACC_WIDTH = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           mode,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out,
    output logic                 zero,
    output logic                 neg,
    output logic                 borrow,
    output logic                 ovf,
    output logic [ACC_WIDTH-1:0] acc
);

    // Everything a beat needs to produce its result in the output stage.
    typedef struct packed {
        logic [WIDTH:0] d;       // {0,a} - {0,b}; MSB is the unsigned borrow
        logic           is_abs;  // modes 01 and 10
        logic           is_sad;  // mode 10
        logic           a_msb;
        logic           b_msb;
    } beat_t;

    logic advance;

    // The whole pipe moves in lockstep; bubbles are carried, not squeezed out.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // -------------------------------------------------------------------------
    // Stage 1 arithmetic (combinational, captured by the first register)
    // -------------------------------------------------------------------------
    beat_t in_beat;

    // NOTE: always_comb assigns a full default first so no path can leave a
    // variable unassigned and infer a latch.
    always_comb begin
        in_beat        = '0;
        in_beat.d      = {1'b0, a} - {1'b0, b};
        in_beat.is_abs = (mode == 2'b01) || (mode == 2'b10);
        in_beat.is_sad = (mode == 2'b10);
        in_beat.a_msb  = a[WIDTH-1];
        in_beat.b_msb  = b[WIDTH-1];
    end

    // pipe_beat[k] / pipe_valid[k] is what feeds register k+1; index 0 is
    // the incoming operand beat.
    beat_t pipe_beat  [STAGES];
    logic  pipe_valid [STAGES];

    assign pipe_beat[0]  = in_beat;
    assign pipe_valid[0] = in_valid;

    // -------------------------------------------------------------------------
    // Stages 1 .. STAGES-1: carry the beat unchanged
    // -------------------------------------------------------------------------
    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        beat_t beat_q;
        logic  valid_q;

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of block order.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
            end else if (advance) begin
                valid_q <= pipe_valid[k-1];
            end
        end

        // NOTE: payload registers are qualified by valid_q, so they need no
        // reset; only the valid bits must come out of reset cleared.
        always_ff @(posedge clk) begin
            if (advance) begin
                beat_q <= pipe_beat[k-1];
            end
        end

        assign pipe_beat[k]  = beat_q;
        assign pipe_valid[k] = valid_q;
    end

    // -------------------------------------------------------------------------
    // Output stage: result selection, flags and accumulator
    // -------------------------------------------------------------------------
    beat_t                last_beat;
    logic                 last_valid;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     magnitude;
    logic [WIDTH-1:0]     result;
    logic                 res_neg;
    logic                 res_ovf;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH:0]   acc_sum;
    logic [ACC_WIDTH-1:0] acc_next;

    assign last_beat  = pipe_beat[STAGES-1];
    assign last_valid = pipe_valid[STAGES-1];

    always_comb begin
        diff      = last_beat.d[WIDTH-1:0];
        // When a < b the wrapped difference is the two's complement of b-a.
        magnitude = last_beat.d[WIDTH] ? ({WIDTH{1'b0}} - diff) : diff;
        result    = last_beat.is_abs ? magnitude : diff;
        res_neg   = !last_beat.is_abs && diff[WIDTH-1];
        res_ovf   = !last_beat.is_abs && (last_beat.a_msb != last_beat.b_msb)
                    && (diff[WIDTH-1] != last_beat.a_msb);

        // Clear-then-add when acc_clr meets a SAD beat; one extra sum bit
        // detects overflow so the accumulator saturates instead of wrapping.
        acc_base  = acc_clr ? '0 : acc;
        acc_sum   = {1'b0, acc_base} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, result};
        acc_next  = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            borrow    <= 1'b0;
            ovf       <= 1'b0;
            acc       <= '0;
        end else begin
            if (advance) begin
                out_valid <= last_valid;
                if (last_valid) begin
                    out    <= result;
                    zero   <= (result == '0);
                    neg    <= res_neg;
                    borrow <= last_beat.d[WIDTH];
                    ovf    <= res_ovf;
                end
            end

            if (advance && last_valid && last_beat.is_sad) begin
                acc <= acc_next;
            end else if (acc_clr) begin
                acc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_diff_pipe.sv
// -----------------------------------------------------------------------------
// tb_diff_pipe -- self-checking bench for diff_pipe (WIDTH=32, STAGES=2,
// ACC_WIDTH=33). A negedge monitor keeps a scoreboard of accepted beats whose
// expected results come from plain integer arithmetic; scenario tasks add
// directed checks for latency, flags, accumulator, stall and reset behaviour.
// -----------------------------------------------------------------------------
module tb_diff_pipe;

    localparam int     WIDTH     = 32;
    localparam int     STAGES    = 2;
    localparam int     ACC_WIDTH = 33;
    localparam longint ACC_MAX   = (longint'(1) << ACC_WIDTH) - 1;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b0;
    logic                 in_valid  = 1'b0;
    logic                 in_ready;
    logic [WIDTH-1:0]     a         = '0;
    logic [WIDTH-1:0]     b         = '0;
    logic [1:0]           mode      = 2'b00;
    logic                 acc_clr   = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [WIDTH-1:0]     out;
    logic                 zero, neg, borrow, ovf;
    logic [ACC_WIDTH-1:0] acc;

    diff_pipe #(
        .WIDTH    (WIDTH),
        .STAGES   (STAGES),
        .ACC_WIDTH(ACC_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .mode     (mode),
        .acc_clr  (acc_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .zero     (zero),
        .neg      (neg),
        .borrow   (borrow),
        .ovf      (ovf),
        .acc      (acc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] out;
        logic             zero;
        logic             neg;
        logic             borrow;
        logic             ovf;
        logic             sad;
        logic             clr;
    } exp_t;

    exp_t   sb[$];
    longint model_acc = 0;
    int     checks    = 0;
    int     errors    = 0;
    int     n_out     = 0;
    logic   next_clr  = 1'b0;

    function automatic longint sat(input longint v);
        return (v > ACC_MAX) ? ACC_MAX : v;
    endfunction

    // Reference result from the arithmetic definitions, using wide integers.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic [1:0] m, input logic clr);
        exp_t   e;
        longint true_diff;
        bit     is_abs;
        is_abs    = (m == 2'b01) || (m == 2'b10);
        true_diff = longint'($signed(x)) - longint'($signed(y));
        e         = '0;
        e.borrow  = (x < y);
        if (is_abs) begin
            e.out = (x >= y) ? (x - y) : (y - x);
            e.neg = 1'b0;
            e.ovf = 1'b0;
        end else begin
            e.out = x - y;
            e.neg = e.out[WIDTH-1];
            e.ovf = (true_diff > 64'sd2147483647) || (true_diff < -64'sd2147483648);
        end
        e.zero = (e.out == '0);
        e.sad  = (m == 2'b10);
        e.clr  = clr;
        return e;
    endfunction

    // Scoreboard monitor: inputs and outputs are stable at the negedge, so a
    // handshake seen here is the transfer that happens on the next posedge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got out=%h with no beat outstanding", out);
                end else begin
                    e = sb.pop_front();
                    if (e.sad) model_acc = e.clr ? sat(longint'(e.out)) : sat(model_acc + longint'(e.out));
                    if ({out, zero, neg, borrow, ovf} !== {e.out, e.zero, e.neg, e.borrow, e.ovf}) begin
                        errors++;
                        $display("FAIL result: got out=%h z=%b n=%b b=%b v=%b, expected out=%h z=%b n=%b b=%b v=%b",
                                 out, zero, neg, borrow, ovf, e.out, e.zero, e.neg, e.borrow, e.ovf);
                    end
                    checks++;
                    if (acc !== ACC_WIDTH'(model_acc)) begin
                        errors++;
                        $display("FAIL acc_at_result: got %h, expected %h", acc, ACC_WIDTH'(model_acc));
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(a, b, mode, next_clr));
        end
    end

    // Present one beat, wait (bounded) for acceptance, return 1ns after the
    // accepting edge with in_valid dropped.
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [1:0] m);
        int n = 0;
        in_valid = 1'b1;
        a = x;
        b = y;
        mode = m;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at %b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Send and wait until the beat sits in the output register (no stall).
    task automatic send_wait(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [1:0] m);
        send(x, y, m);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        while ((out_valid || sb.size() != 0) && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (out_valid || sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: out_valid=%b outstanding=%0d, expected 0 and 0", out_valid, sb.size());
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({out_valid, out, zero, neg, borrow, ovf} !== '0 || acc !== '0) begin
            errors++;
            $display("FAIL reset_values: out_valid=%b out=%h flags=%b%b%b%b acc=%h, expected all 0",
                     out_valid, out, zero, neg, borrow, ovf, acc);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic_sub();
        send(32'd10, 32'd7, 2'b00);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: out_valid=%b one cycle after accept, expected 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out !== 32'd3 || {zero, neg, borrow, ovf} !== 4'b0000) begin
            errors++;
            $display("FAIL basic_10_7: valid=%b out=%h flags=%b%b%b%b, expected 1 00000003 0000",
                     out_valid, out, zero, neg, borrow, ovf);
        end
        send_wait(32'd7, 32'd7, 2'b00);
        checks++;
        if (out !== 32'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL basic_7_7: out=%h zero=%b, expected 00000000 1", out, zero);
        end
    endtask

    task automatic test_signed_edges();
        send_wait(32'd7, 32'd10, 2'b00);
        checks++;
        if (out !== 32'hFFFF_FFFD || {neg, borrow, ovf} !== 3'b110) begin
            errors++;
            $display("FAIL signed_7_10: out=%h n=%b b=%b v=%b, expected fffffffd 1 1 0", out, neg, borrow, ovf);
        end
        send_wait(32'h8000_0000, 32'd1, 2'b00);
        checks++;
        if (out !== 32'h7FFF_FFFF || {neg, borrow, ovf} !== 3'b001) begin
            errors++;
            $display("FAIL signed_min_1: out=%h n=%b b=%b v=%b, expected 7fffffff 0 0 1", out, neg, borrow, ovf);
        end
        send_wait(32'd5, 32'd9, 2'b11);
        checks++;
        if (out !== 32'hFFFF_FFFC || neg !== 1'b1) begin
            errors++;
            $display("FAIL mode11_as_sub: out=%h n=%b, expected fffffffc 1", out, neg);
        end
    endtask

    task automatic test_abs_sad();
        logic [ACC_WIDTH-1:0] exp_acc [3];
        logic [WIDTH-1:0]     xs      [3];
        logic [WIDTH-1:0]     ys      [3];
        xs = '{32'd5, 32'd2, 32'd9};
        ys = '{32'd2, 32'd5, 32'd9};
        exp_acc = '{33'd3, 33'd6, 33'd6};
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        model_acc = 0;
        checks++;
        if (acc !== '0) begin
            errors++;
            $display("FAIL acc_clr_alone: got %h, expected 0", acc);
        end
        send_wait(32'd7, 32'd10, 2'b01);
        checks++;
        if (out !== 32'd3 || borrow !== 1'b1 || neg !== 1'b0) begin
            errors++;
            $display("FAIL abs_7_10: out=%h b=%b n=%b, expected 00000003 1 0", out, borrow, neg);
        end
        for (int i = 0; i < 3; i++) begin
            send_wait(xs[i], ys[i], 2'b10);
            checks++;
            if (acc !== exp_acc[i]) begin
                errors++;
                $display("FAIL sad_acc_%0d: got %h, expected %h", i, acc, exp_acc[i]);
            end
        end
        checks++;
        if (zero !== 1'b1) begin
            errors++;
            $display("FAIL sad_zero: got %b, expected 1", zero);
        end
    endtask

    task automatic test_sad_saturation();
        longint exp_sum = 0;
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        model_acc = 0;
        for (int i = 0; i < 4; i++) begin
            send_wait(32'hFFFF_FFFF, 32'd0, 2'b10);
            exp_sum = sat(exp_sum + 64'h0000_0000_FFFF_FFFF);
            checks++;
            if (acc !== ACC_WIDTH'(exp_sum)) begin
                errors++;
                $display("FAIL sad_sat_%0d: got %h, expected %h", i, acc, ACC_WIDTH'(exp_sum));
            end
        end
    endtask

    task automatic test_clr_coincident();
        next_clr = 1'b1;
        send(32'd4, 32'd1, 2'b10);
        next_clr = 1'b0;
        acc_clr  = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        checks++;
        if (acc !== 33'd3 || out !== 32'd3) begin
            errors++;
            $display("FAIL clr_with_sad: acc=%h out=%h, expected 3 and 3", acc, out);
        end
    endtask

    task automatic test_back_to_back();
        int               n0;
        logic [WIDTH-1:0] held;
        drain();
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    int n = 0;
                    in_valid = 1'b1;
                    a    = $urandom;
                    b    = $urandom;
                    mode = 2'($urandom_range(0, 3));
                    @(negedge clk);
                    while (!in_ready && n < 50) begin
                        n++;
                        @(negedge clk);
                    end
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                held = out;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== held) begin
                        errors++;
                        $display("FAIL stall_%0d: in_ready=%b out_valid=%b out=%h, expected 0 1 %h",
                                 c, in_ready, out_valid, out, held);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (n_out - n0 != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, expected 8", n_out - n0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            mode      = 2'($urandom_range(0, 3));
            b         = $urandom;
            a         = ($urandom_range(0, 7) == 0) ? b : $urandom;
            @(posedge clk);
            #1;
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        drain();
        send(32'd3, 32'd1, 2'b10);
        send(32'd6, 32'd1, 2'b10);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midflight_setup: out_valid=%b, expected 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || acc !== '0 || out !== '0) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b acc=%h out=%h, expected 0 0 0", out_valid, acc, out);
        end
        sb.delete();
        model_acc = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stale_after_reset_%0d: out_valid=%b in_ready=%b, expected 0 1",
                         c, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sub();
        test_signed_edges();
        test_abs_sad();
        test_sad_saturation();
        test_clr_coincident();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/diff_pipe.md
Name: diff_pipe

Overview:
Parametrised, pipelined difference unit for the miniRISC datapath. It is the successor to the combinational 32-bit a-b subtractor. It adds:
- configurable width and latency
- valid/ready flow control with backpressure
- status flags
- absolute-difference and sum-of-absolute-differences (SAD) accumulate modes

It sits between the issue logic and writeback as a multi-cycle execution unit.

Parameters:
WIDTH, 32, operand and result width in bits (>=4)
STAGES, 2, pipeline depth and fixed latency in cycles (1..4)
ACC_WIDTH, 40, SAD accumulator width (>= WIDTH)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept operand beat
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
mode  input  2  00 signed sub, 01 unsigned abs diff, 10 SAD accumulate, 11 reserved (treated as 00)
acc_clr  input  1  synchronous accumulator clear
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result
out  output  WIDTH  result
zero  output  1  out == 0
neg  output  1  sign bit of a-b (mode 00/11 only, else 0)
borrow  output  1  a < b unsigned
ovf  output  1  signed overflow of a-b (mode 00/11 only, else 0)
acc  output  ACC_WIDTH  SAD accumulator value

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: all stage valid bits 0, out_valid=0, out=0, all flags 0, acc=0. in_ready=1 after reset.
- Reset mid-operation: every in-flight beat is discarded. No result is emitted for those beats after release.
- Handshake:
  - An input beat transfers when in_valid && in_ready.
  - A result transfers when out_valid && out_ready.
  - out and flags hold stable while out_valid && !out_ready.
- Pipeline: STAGES registered stages, each carrying a valid bit.
  - Stage 1 computes the full (WIDTH+1)-bit difference d = {0,a} - {0,b}, plus mode.
  - The final stage registers out, flags and valid.
  - Intermediate stages pass data through.
- Advance rule: the whole pipeline advances when !out_valid || out_ready.
  - in_ready equals this advance condition (combinational from out_valid/out_ready only, not from in_valid).
  - Bubbles are not compressed.
- Latency: a beat accepted in cycle N appears with out_valid=1 in cycle N+STAGES if never stalled. Throughput is 1 beat/cycle with out_ready held high.
- Arithmetic:
  - Mode 00/11: out = (a-b) mod 2^WIDTH. neg = out[WIDTH-1]. ovf = (a[MSB]!=b[MSB]) && (out[MSB]!=a[MSB]).
  - Mode 01/10: out = (a>=b unsigned) ? a-b : b-a.
  - borrow = d[WIDTH] in every mode. zero = (out==0) in every mode.
- Accumulator:
  - acc updates only when a mode-10 beat is loaded into the final stage: acc <= acc + zero-extended out.
  - It saturates at 2^ACC_WIDTH-1 and never wraps.
  - acc_clr=1 alone gives acc <= 0 on the next edge.
  - acc_clr coinciding with a mode-10 load gives acc <= that beat's abs diff (clear-then-add).
  - acc_clr does not affect pipeline contents or flags.
- Backpressure: with out_valid=1 and out_ready=0:
  - No stage advances, in_ready=0, acc does not change.
  - No beat is lost or duplicated.

Test Plan:
- Basic sub: WIDTH=32, STAGES=2, mode 00. Beat a=10,b=7 then a=7,b=7, out_ready=1 → two results 2 cycles after each acceptance: out=3 (all flags 0), then out=0 with zero=1.
- Signed edges: mode 00. a=7,b=10 → out=0xFFFFFFFD, neg=1, borrow=1, ovf=0. a=0x80000000,b=1 → out=0x7FFFFFFF, ovf=1, neg=0.
- Abs and SAD: mode 01 a=7,b=10 → out=3, borrow=1. Then mode 10 beats (5,2),(2,5),(9,9) → acc sequence 3,6,6; zero=1 on third.
- SAD saturation/clear:
  - Preload via mode 10 with WIDTH=32, ACC_WIDTH=33 using 0xFFFFFFFF beats → acc sticks at 0x1FFFFFFFF.
  - acc_clr coincident with a beat of |4-1| → acc=3.
- Backpressure: stream 8 beats back-to-back, out_ready low for 5 cycles mid-stream → in_ready=0 while stalled, out stable, all 8 results in order, none duplicated.
- Reset mid-flight: assert rst_n=0 with 2 beats in the pipe → out_valid=0, acc=0 immediately (asynchronous). After release, no stale beat appears; in_ready=1.
